// File: rtl/aui_pkg.sv
// Alignment-marker constants and lock FSM state type, shared by the marker
// generator and the marker lock logic.
package aui_pkg;

    // Common marker field, bits [63:40] of every alignment marker word.
    localparam logic [23:0] AM_CM = 24'hA5_3C_96;

    // Lane-unique marker field, bits [39:16], one entry per lane.
    localparam logic [23:0] AM_UM [0:15] = '{
        24'hC1_68_21, 24'h9D_71_8E, 24'h59_4B_E8, 24'h4D_95_7B,
        24'hF5_07_09, 24'hDD_14_C2, 24'h9A_4A_26, 24'h7B_45_66,
        24'hA0_24_76, 24'h68_C9_FB, 24'hFD_6C_99, 24'hB9_91_55,
        24'h5C_B9_B2, 24'h1A_F8_BD, 24'h83_C7_CA, 24'h35_36_CD
    };

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } am_lock_state_t;

endpackage

// File: rtl/am_match.sv
// Combinational alignment-marker decoder: flags a word whose marker fields
// match one of the lane markers and reports that lane. BIP bits never reach it.
module am_match
    import aui_pkg::*;
#(
    parameter int NUMBER_LANES = 16
) (
    input  logic [47:0] i_data,
    output logic        match,
    output logic [3:0]  lane_id
);

    always_comb begin
        match   = 1'b0;
        lane_id = 4'd0;
        for (int k = 0; k < NUMBER_LANES; k++) begin
            if (i_data[47:24] == AM_CM && i_data[23:0] == AM_UM[k]) begin
                match   = 1'b1;
                lane_id = 4'(k);
            end
        end
    end

endmodule

// File: rtl/alignment_marker_lock.sv
// Alignment-marker lock: hunts for a lane marker, verifies it at the marker
// period, then tracks it and marks each expected marker position on the output.
//
// state  | meaning
// HUNT   | searching every valid word for any lane marker
// VERIFY | candidate lane found, confirming at the following marker positions
// LOCKED | lane and period confirmed, counting missed markers
module alignment_marker_lock
    import aui_pkg::*;
#(
    parameter int DATA_WIDTH   = 64,
    parameter int NUMBER_LANES = 16,
    parameter int AM_PERIOD    = 64,
    parameter int LOSS_COUNT   = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_valid,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic                  o_valid,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_am,
    output logic                  o_am_lock,
    output logic [3:0]            o_lane_id,
    output logic                  o_lock_lost
);

    localparam int CW = $clog2(AM_PERIOD);
    localparam int BW = $clog2(LOSS_COUNT + 1);
    localparam logic [CW-1:0] CNT_LAST  = CW'(AM_PERIOD - 1);
    localparam logic [BW-1:0] LOSS_LAST = BW'(LOSS_COUNT - 1);

    am_lock_state_t state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [1:0]     good_q, good_d;
    logic [BW-1:0]  bad_q, bad_d;
    logic [3:0]     lane_q, lane_d;

    logic                  valid_q, valid_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  am_q, am_d;
    logic                  am_lock_q, am_lock_d;
    logic [3:0]            lane_id_q, lane_id_d;
    logic                  lock_lost_q, lock_lost_d;

    logic       match;
    logic [3:0] match_lane;
    logic       at_last;
    logic       same_lane;

    am_match #(
        .NUMBER_LANES (NUMBER_LANES)
    ) u_am_match (
        .i_data  (i_data[63:16]),
        .match   (match),
        .lane_id (match_lane)
    );

    assign at_last   = (cnt_q == CNT_LAST);
    assign same_lane = match && (match_lane == lane_q);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        good_d      = good_q;
        bad_d       = bad_q;
        lane_d      = lane_q;
        am_d        = 1'b0;
        lock_lost_d = 1'b0;

        if (i_valid) begin
            cnt_d = at_last ? '0 : cnt_q + CW'(1);
            unique case (state_q)
                HUNT: begin
                    if (match) begin
                        lane_d  = match_lane;
                        cnt_d   = '0;
                        good_d  = 2'd1;
                        state_d = VERIFY;
                    end
                end
                VERIFY: begin
                    // A failing word drops straight to HUNT; it is not a new candidate.
                    if (at_last) begin
                        if (same_lane) begin
                            good_d = good_q + 2'd1;
                            if (good_q == 2'd2) begin
                                state_d = LOCKED;
                                bad_d   = '0;
                            end
                        end else begin
                            state_d = HUNT;
                        end
                    end
                end
                LOCKED: begin
                    if (at_last) begin
                        am_d = 1'b1;
                        if (same_lane) begin
                            bad_d = '0;
                        end else if (bad_q == LOSS_LAST) begin
                            bad_d       = '0;
                            state_d     = HUNT;
                            lock_lost_d = 1'b1;
                        end else begin
                            bad_d = bad_q + BW'(1);
                        end
                    end
                end
                default: state_d = HUNT;
            endcase
        end

        valid_d   = i_valid;
        data_d    = i_data;
        am_lock_d = (state_d == LOCKED);
        lane_id_d = lane_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= HUNT;
            cnt_q       <= '0;
            good_q      <= '0;
            bad_q       <= '0;
            lane_q      <= '0;
            valid_q     <= 1'b0;
            data_q      <= '0;
            am_q        <= 1'b0;
            am_lock_q   <= 1'b0;
            lane_id_q   <= '0;
            lock_lost_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            good_q      <= good_d;
            bad_q       <= bad_d;
            lane_q      <= lane_d;
            valid_q     <= valid_d;
            data_q      <= data_d;
            am_q        <= am_d;
            am_lock_q   <= am_lock_d;
            lane_id_q   <= lane_id_d;
            lock_lost_q <= lock_lost_d;
        end
    end

    assign o_valid     = valid_q;
    assign o_data      = data_q;
    assign o_am        = am_q;
    assign o_am_lock   = am_lock_q;
    assign o_lane_id   = lane_id_q;
    assign o_lock_lost = lock_lost_q;

endmodule
